issueq_freelist: RTL and testbench

Circular free list of issue-queue entry indices, directly downstream of the issue-queue freeing logic and upstream of dispatch. Each cycle it accepts up to four freed entry indices and appends them in port order. It presents the four oldest free indices to dispatch, pops all four when dispatch consumes them, and raises a stall when fewer than four entries are free.

---
 rtl/issueq_freelist.sv | 122 ++++++++++++
 tb/tb_issueq_freelist.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/issueq_freelist.sv
// Circular free list of issue-queue entry indices.
// Freed indices are appended at the tail in port order. Dispatch takes the
// four oldest indices from the head, all four or none. Stall is raised
// whenever fewer than four indices are held. A push that would take the
// occupancy past the list depth is dropped and latches a sticky overflow flag.
module issueq_freelist #(
    parameter int SIZE_ISSUEQ     = 64,
    parameter int SIZE_ISSUEQ_LOG = 6
) (
    input  logic                       clock,
    input  logic                       reset_n,

    input  logic                       freedValid0_i,
    input  logic                       freedValid1_i,
    input  logic                       freedValid2_i,
    input  logic                       freedValid3_i,
    input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry0_i,
    input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry1_i,
    input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry2_i,
    input  logic [SIZE_ISSUEQ_LOG-1:0] freedEntry3_i,

    input  logic                       dispatchReady_i,

    output logic [SIZE_ISSUEQ_LOG-1:0] freeEntry0_o,
    output logic [SIZE_ISSUEQ_LOG-1:0] freeEntry1_o,
    output logic [SIZE_ISSUEQ_LOG-1:0] freeEntry2_o,
    output logic [SIZE_ISSUEQ_LOG-1:0] freeEntry3_o,
    output logic                       stall_o,
    output logic [SIZE_ISSUEQ_LOG:0]   freeCount_o,
    output logic                       overflow_o
);

    localparam int PW = SIZE_ISSUEQ_LOG;       // pointer / index width
    localparam int CW = SIZE_ISSUEQ_LOG + 1;   // count width (0..SIZE_ISSUEQ)
    localparam int SW = SIZE_ISSUEQ_LOG + 2;   // headroom for count + 4

    logic [PW-1:0] slot_q [SIZE_ISSUEQ];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [3:0]    valid;
    logic [PW-1:0] entry  [4];
    logic [PW-1:0] wr_idx [4];
    logic [3:0]    wr_en;
    logic [2:0]    num_push;
    logic          pop;
    logic [SW-1:0] count_sum;
    logic          push_ok;

    assign valid    = {freedValid3_i, freedValid2_i, freedValid1_i, freedValid0_i};
    assign entry[0] = freedEntry0_i;
    assign entry[1] = freedEntry1_i;
    assign entry[2] = freedEntry2_i;
    assign entry[3] = freedEntry3_i;

    // Pack valid ports into consecutive slots starting at the tail.
    always_comb begin
        num_push = '0;
        for (int k = 0; k < 4; k++) begin
            wr_idx[k] = tail_q + PW'(num_push);
            num_push  = num_push + {2'b00, valid[k]};
        end
    end

    assign pop = dispatchReady_i & ~stall_o;

    // Full-width occupancy after this cycle; pops are always at least four
    // deep when taken, so the subtraction cannot wrap.
    assign count_sum = SW'(count_q) + SW'(num_push) - (pop ? SW'(4) : SW'(0));
    assign push_ok   = (count_sum <= SW'(SIZE_ISSUEQ));
    assign wr_en     = valid & {4{push_ok}};

    // Next-state pointers, occupancy and sticky overflow; an overflowing
    // cycle still pops but discards every push.
    always_comb begin
        head_d     = pop ? head_q + PW'(4) : head_q;
        overflow_d = overflow_q | ~push_ok;
        if (push_ok) begin
            tail_d  = tail_q + PW'(num_push);
            count_d = count_sum[CW-1:0];
        end else begin
            tail_d  = tail_q;
            count_d = count_q - (pop ? CW'(4) : CW'(0));
        end
    end

    // State registers; reset reloads the list with every index in order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= CW'(SIZE_ISSUEQ);
            overflow_q <= 1'b0;
            for (int i = 0; i < SIZE_ISSUEQ; i++) begin
                slot_q[i] <= PW'(i);
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k]) begin
                    slot_q[wr_idx[k]] <= entry[k];
                end
            end
        end
    end

    // Head window is read from registered state only, so a same-cycle push
    // never shows up here until the following cycle.
    assign freeEntry0_o = slot_q[head_q];
    assign freeEntry1_o = slot_q[head_q + PW'(1)];
    assign freeEntry2_o = slot_q[head_q + PW'(2)];
    assign freeEntry3_o = slot_q[head_q + PW'(3)];
    assign stall_o      = (count_q < CW'(4));
    assign freeCount_o  = count_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_issueq_freelist.sv
// Bench for issueq_freelist: table of {stimulus, expected outputs after the
// edge} records, applied through a scoreboard queue, plus hand-written
// asynchronous-reset sequences.
module tb_issueq_freelist;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       fv0, fv1, fv2, fv3;
    logic [5:0] fe0, fe1, fe2, fe3;
    logic       rdy;
    logic [5:0] oe0, oe1, oe2, oe3;
    logic       stall;
    logic [6:0] cnt;
    logic       ovf;

    int vec_cnt = 0;
    int err_cnt = 0;

    typedef struct {
        string           name;
        logic [3:0]      v;
        logic [3:0][5:0] e;
        logic            rdy;
        logic [3:0][5:0] x;
        int              xcnt;
        logic            xstall;
        logic            xovf;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   split;

    issueq_freelist #(.SIZE_ISSUEQ(64), .SIZE_ISSUEQ_LOG(6)) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .freedValid0_i   (fv0),
        .freedValid1_i   (fv1),
        .freedValid2_i   (fv2),
        .freedValid3_i   (fv3),
        .freedEntry0_i   (fe0),
        .freedEntry1_i   (fe1),
        .freedEntry2_i   (fe2),
        .freedEntry3_i   (fe3),
        .dispatchReady_i (rdy),
        .freeEntry0_o    (oe0),
        .freeEntry1_o    (oe1),
        .freeEntry2_o    (oe2),
        .freeEntry3_o    (oe3),
        .stall_o         (stall),
        .freeCount_o     (cnt),
        .overflow_o      (ovf)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0][5:0] pk(int a0, int a1, int a2, int a3);
        logic [3:0][5:0] r;
        r[0] = 6'(a0);
        r[1] = 6'(a1);
        r[2] = 6'(a2);
        r[3] = 6'(a3);
        return r;
    endfunction

    // Value written into slot s during the wrap phase.
    function automatic int f(int s);
        return (s % 64) ^ 21;
    endfunction

    function automatic void add(string nm, logic [3:0] v, logic [3:0][5:0] e, logic r,
                                logic [3:0][5:0] x, int c, logic s, logic o);
        vec_t t;
        t.name = nm; t.v = v; t.e = e; t.rdy = r;
        t.x = x; t.xcnt = c; t.xstall = s; t.xovf = o;
        tbl.push_back(t);
    endfunction

    task automatic chk(string nm, int act, int expv);
        vec_cnt++;
        if (act != expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    task automatic idle_inputs();
        {fv3, fv2, fv1, fv0} = 4'b0000;
        fe0 = '0; fe1 = '0; fe2 = '0; fe3 = '0;
        rdy = 1'b0;
    endtask

    task automatic check_outputs(string nm, logic [3:0][5:0] x, int c, logic s, logic o);
        chk({nm, ".e0"},    int'(oe0),   int'(x[0]));
        chk({nm, ".e1"},    int'(oe1),   int'(x[1]));
        chk({nm, ".e2"},    int'(oe2),   int'(x[2]));
        chk({nm, ".e3"},    int'(oe3),   int'(x[3]));
        chk({nm, ".count"}, int'(cnt),   c);
        chk({nm, ".stall"}, int'(stall), int'(s));
        chk({nm, ".ovf"},   int'(ovf),   int'(o));
    endtask

    // Drive one record, queue its expectation, compare after the edge.
    task automatic apply(vec_t t);
        vec_t r;
        {fv3, fv2, fv1, fv0} = t.v;
        fe0 = t.e[0]; fe1 = t.e[1]; fe2 = t.e[2]; fe3 = t.e[3];
        rdy = t.rdy;
        exp_q.push_back(t);
        @(posedge clock);
        #1;
        idle_inputs();
        if (exp_q.size() == 0) begin
            chk({t.name, ".scoreboard_empty"}, 0, 1);
        end else begin
            r = exp_q.pop_front();
            check_outputs(r.name, r.x, r.xcnt, r.xstall, r.xovf);
        end
    endtask

    initial begin
        // ---- table: overflow segment (from reset) ----
        add("ovf_push",   4'b0001, pk(33,0,0,0), 1'b0, pk(0,1,2,3), 64, 1'b0, 1'b1);
        add("ovf_sticky", 4'b0000, pk(0,0,0,0),  1'b0, pk(0,1,2,3), 64, 1'b0, 1'b1);
        add("ovf_pop",    4'b0000, pk(0,0,0,0),  1'b1, pk(4,5,6,7), 60, 1'b0, 1'b1);
        split = tbl.size();

        // ---- table: drain, refill, push/pop, wrap (after mid-test reset) ----
        for (int i = 0; i < 16; i++) begin
            int h;
            h = (4 * (i + 1)) % 64;
            add($sformatf("drain%0d", i), 4'b0000, pk(0,0,0,0), 1'b1,
                pk(h, h+1, h+2, h+3), 64 - 4 * (i + 1), (i == 15), 1'b0);
        end
        add("drain_extra", 4'b0000, pk(0,0,0,0),     1'b1, pk(0,1,2,3),     0, 1'b1, 1'b0);
        add("push_sparse", 4'b1101, pk(5,9,12,40),   1'b0, pk(5,12,40,3),   3, 1'b1, 1'b0);
        add("push_one",    4'b1000, pk(0,0,0,7),     1'b0, pk(5,12,40,7),   4, 1'b0, 1'b0);
        add("fill8",       4'b1111, pk(20,21,22,23), 1'b0, pk(5,12,40,7),   8, 1'b0, 1'b0);
        add("pushpop",     4'b1111, pk(30,31,32,33), 1'b1, pk(20,21,22,23), 8, 1'b0, 1'b0);
        add("pop_a",       4'b0000, pk(0,0,0,0),     1'b1, pk(30,31,32,33), 4, 1'b0, 1'b0);
        add("pop_b",       4'b0000, pk(0,0,0,0),     1'b1, pk(12,13,14,15), 0, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            int t;
            t = 12 + 4 * c;
            add($sformatf("wfill%0d", c), 4'b1111, pk(f(t), f(t+1), f(t+2), f(t+3)), 1'b0,
                pk(f(12), f(13), f(14), f(15)), 4 * (c + 1), 1'b0, 1'b0);
        end
        add("wfill_two", 4'b0011, pk(f(60), f(61), 0, 0), 1'b0,
            pk(f(12), f(13), f(14), f(15)), 50, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            int h;
            h = 12 + 4 * (i + 1);
            add($sformatf("wdrain%0d", i), 4'b0000, pk(0,0,0,0), 1'b1,
                pk(f(h), f(h+1), f(h+2), f(h+3)), 50 - 4 * (i + 1), 1'b0, 1'b0);
        end
        add("wdrain11",  4'b0000, pk(0,0,0,0), 1'b1, pk(f(60), f(61), 62, 63), 2, 1'b1, 1'b0);
        add("wrap_push", 4'b1111, pk(f(62), f(63), f(0), f(1)), 1'b0,
            pk(f(60), f(61), f(62), f(63)), 6, 1'b0, 1'b0);
        add("wrap_pop",  4'b0000, pk(0,0,0,0), 1'b1, pk(f(0), f(1), 40, 7), 2, 1'b1, 1'b0);

        // ---- reset and reset-state check ----
        idle_inputs();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("reset", pk(0,1,2,3), 64, 1'b0, 1'b0);

        for (int i = 0; i < split; i++) begin
            apply(tbl[i]);
        end

        // ---- hand sequence: asynchronous reset mid-operation ----
        #2;
        reset_n = 1'b0;
        #1;
        check_outputs("async_rst", pk(0,1,2,3), 64, 1'b0, 1'b0);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check_outputs("post_rst", pk(0,1,2,3), 64, 1'b0, 1'b0);

        for (int i = split; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
